input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Sits directly upstream of the Pong top level.
- Turns the five raw pushbutton pins into clean controls: player one up/down, player two up/down, and enter.
- Per button: 2-flop synchroniser, tick-based debounce, stable level, and single-cycle press/release pulses.
- Also produces the two-player pause-navigation combos from debounced levels; replaces the ad-hoc enter debounce and raw AND gating in the top level.

Parameters:
- NUM_BUTTONS, 5, number of channels; bit map: 0=p1_up, 1=p1_down, 2=p2_up, 3=p2_down, 4=enter.
- TICK_DIV, 6000, clk cycles per debounce sample tick (12 MHz gives 0.5 ms).
- DEBOUNCE_TICKS, 100, consecutive ticks a new input value must persist before it is accepted.
- REPEAT_DELAY, 800, ticks held before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 200, ticks between auto-repeat pulses (used only with the optional feature).

Ports:
- clk  in  1  system clock (12 MHz HSOSC)
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- btn_raw  in  NUM_BUTTONS  raw, asynchronous, bouncing button pins; active-high
- btn_level  out  NUM_BUTTONS  debounced stable level per button
- btn_press  out  NUM_BUTTONS  1-clk pulse on each accepted 0->1 change (plus repeats when enabled)
- btn_release  out  NUM_BUTTONS  1-clk pulse on each accepted 1->0 change
- pause_up  out  1  btn_level[0] & btn_level[2]
- pause_down  out  1  btn_level[1] & btn_level[3]
- tick_en  out  1  1-clk strobe of the sample prescaler

Behaviour:
- Reset: all outputs 0. Prescaler, synchronisers, counters and levels are all 0. Reset takes effect immediately on the falling edge, including mid-count; on release, counting restarts from 0.
- Prescaler:
  - Counter 0..TICK_DIV-1, wraps to 0.
  - tick_en is high in the cycle the count equals TICK_DIV-1.
  - Width is ceil(log2(TICK_DIV)).
- Synchroniser: two flops per channel; the synchronised value s lags btn_raw by 2 clk.
- Debounce, per channel (counter width ceil(log2(DEBOUNCE_TICKS+1))):
  - s == level, any cycle: count <= 0.
  - s != level and tick_en:
    - if count == DEBOUNCE_TICKS-1: level <= s, count <= 0;
    - otherwise count <= count+1.
  - s != level, no tick_en: count holds.
  - A bounce back to the current level for even one clk clears the count, so glitches shorter than DEBOUNCE_TICKS ticks never reach btn_level.
- Pulses:
  - btn_press / btn_release are registered.
  - Each is high for exactly the one clk in which the level register changes (same edge the new level is written).
  - The press pulse for a channel never coincides with its release pulse.
  - Channels are fully independent; simultaneous changes on several channels give simultaneous pulses.
- Latency: from a clean btn_raw edge to the btn_level change is between 2+TICK_DIV*(DEBOUNCE_TICKS-1)+1 and 2+TICK_DIV*DEBOUNCE_TICKS+1 clk.
- Combos: pause_up and pause_down are combinational ANDs of registered levels (glitch-free). Individual channel outputs are not suppressed while a combo is active.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTOREPEAT_EN
- Defined:
  - A per-channel hold counter clears on the press pulse and counts tick_en while level=1.
  - At REPEAT_DELAY ticks, an extra btn_press pulse is issued; thereafter one more every REPEAT_RATE ticks.
  - Repeat pulses are also 1 clk and aligned to the clk following tick_en.
  - The level falling to 0 clears the hold counter immediately; no repeat is issued in the same cycle as a release.
- Undefined: no hold counters are synthesised; btn_press fires only on accepted 0->1 level changes.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=4, REPEAT_RATE=2):
- Reset low for 5 clk, then high, with btn_raw=5'b11111 from time 0 -> all outputs 0 during reset; btn_level=5'b11111 and btn_press=5'b11111 for 1 clk, within 11..15 clk after reset release.
- btn_raw[4] 0->1 held clean -> btn_level[4] rises 11..15 clk later; btn_press[4] high exactly 1 clk; btn_release stays 0.
- btn_raw[0] toggled 1 clk high every 6 clk (bounce) for 100 clk -> btn_level[0]=0 and btn_press[0]=0 throughout.
- btn_raw[0] and btn_raw[2] asserted together, held -> pause_up=1 in the same cycle both levels read 1; pause_down=0. Dropping btn_raw[2] -> btn_release[2] 1 clk and pause_up=0 in the same cycle.
- Reset pulsed low for 1 clk mid-debounce (count=2) on btn_raw[1] -> btn_level[1] stays 0; acceptance requires a full 3 new ticks after release.
- With INPUT_CONDITIONER_AUTOREPEAT_EN, hold btn_raw[1] for 60 clk -> initial press, then a repeat 16 clk later, then every 8 clk; with the macro undefined -> exactly one press.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: sync, debounce and edge-pulse the five Pong buttons; auto-repeat under INPUT_CONDITIONER_AUTOREPEAT_EN
module input_conditioner #(
  parameter int NUM_BUTTONS    = 5,
  parameter int TICK_DIV       = 6000,
  parameter int DEBOUNCE_TICKS = 100,
  parameter int REPEAT_DELAY   = 800,
  parameter int REPEAT_RATE    = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   pause_up,
  output logic                   pause_down,
  output logic                   tick_en
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  logic [PW-1:0] pre;
  logic [NUM_BUTTONS-1:0] s1, s2, accept, rise;
  logic [NUM_BUTTONS-1:0][CW-1:0] cnt;
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_RATE must lie in 1..REPEAT_DELAY");
  end
  assign tick_en    = pre == PW'(TICK_DIV - 1);
  assign pause_up   = btn_level[0] & btn_level[2];
  assign pause_down = btn_level[1] & btn_level[3];
  assign rise       = accept & ~btn_level;
  // sample prescaler, wraps after TICK_DIV cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre <= '0;
    else pre <= tick_en ? '0 : pre + 1'b1;
  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, btn_raw};
  // a channel flips its level on the tick that completes DEBOUNCE_TICKS disagreeing ticks
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      accept[i] = tick_en && s2[i] != btn_level[i] && cnt[i] == CW'(DEBOUNCE_TICKS - 1);
  end
  // disagreement counters, level register and release pulses; any agreeing cycle restarts the count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt         <= '0;
      btn_level   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++)
        cnt[i] <= (s2[i] == btn_level[i] || accept[i]) ? '0 : tick_en ? cnt[i] + 1'b1 : cnt[i];
      btn_level   <= btn_level ^ accept;
      btn_release <= accept & btn_level;
    end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  logic [NUM_BUTTONS-1:0][HW-1:0] hold;
  logic [NUM_BUTTONS-1:0] rise_q, rep;
  // a repeat fires on the tick that completes the hold interval, never alongside a release
  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      rep[i] = tick_en && btn_level[i] && !rise_q[i] && !accept[i] && hold[i] == HW'(REPEAT_DELAY - 1);
  end
  // hold counters restart on the edge press and rewind by REPEAT_RATE after each repeat
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hold      <= '0;
      rise_q    <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++)
        hold[i] <= (!btn_level[i] || rise_q[i]) ? '0 :
                   rep[i] ? HW'(REPEAT_DELAY - REPEAT_RATE) :
                   tick_en ? hold[i] + 1'b1 : hold[i];
      rise_q    <= rise;
      btn_press <= rise | rep;
    end
`else
  // press pulse on accepted rising level changes only
  always_ff @(posedge clk or negedge reset)
    if (!reset) btn_press <= '0;
    else btn_press <= rise;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner with a small prescaler
module tb_input_conditioner;
  typedef struct {
    logic [4:0] press;
    logic [4:0] rel;
    int lo;
    int hi;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] btn_raw = 5'b11111;
  logic [4:0] btn_level, btn_press, btn_release;
  logic pause_up, pause_down, tick_en;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;

  input_conditioner #(
    .NUM_BUTTONS(5), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release),
    .pause_up(pause_up), .pause_down(pause_down), .tick_en(tick_en)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // pulse monitor: every press/release pulse must match the next scoreboard entry
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if ((btn_press | btn_release) != 5'b0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
      end else begin
        e = sb.pop_front();
        if (btn_press !== e.press || btn_release !== e.rel || cyc < e.lo || cyc > e.hi) begin
          bad++;
          $display("FAIL pulse cyc=%0d press=%b release=%b want press=%b release=%b in %0d..%0d",
                   cyc, btn_press, btn_release, e.press, e.rel, e.lo, e.hi);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sb(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({btn_level, btn_press, btn_release, pause_up, pause_down, tick_en} !== 18'd0) begin
        bad++;
        $display("FAIL reset_outputs got=%h want=0", {btn_level, btn_press, btn_release, pause_up, pause_down, tick_en});
      end
    end
    reset = 1'b1;
    sb.push_back('{5'b11111, 5'b00000, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_press_timeout got=pending want=seen"); end
    total++;
    if ({btn_level, pause_up, pause_down} !== 7'b1111111) begin
      bad++;
      $display("FAIL reset_all_high got=%b want=1111111", {btn_level, pause_up, pause_down});
    end
    btn_raw = 5'b00000;
    sb.push_back('{5'b00000, 5'b11111, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0 || btn_level !== 5'b00000) begin
      bad++;
      $display("FAIL all_release got=%b pending=%0d want=00000", btn_level, sb.size());
    end
  endtask

  task automatic test_enter();
    btn_raw = 5'b10000;
    sb.push_back('{5'b10000, 5'b00000, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0 || btn_level !== 5'b10000) begin
      bad++;
      $display("FAIL enter_press got=%b pending=%0d want=10000", btn_level, sb.size());
    end
    btn_raw = 5'b00000;
    sb.push_back('{5'b00000, 5'b10000, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0 || btn_level !== 5'b00000) begin
      bad++;
      $display("FAIL enter_release got=%b pending=%0d want=00000", btn_level, sb.size());
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 100; i++) begin
      btn_raw[0] = (i % 6 == 0);
      step();
      total++;
      if (btn_level[0] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_level i=%0d got=%b want=0", i, btn_level[0]);
      end
    end
    btn_raw[0] = 1'b0;
  endtask

  task automatic test_combo();
    bit seen = 0;
    btn_raw = 5'b00101;
    sb.push_back('{5'b00101, 5'b00000, cyc + 11, cyc + 15});
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      total++;
      if (btn_press[0]) begin
        seen = 1;
        if (pause_up !== 1'b1 || pause_down !== 1'b0) begin
          bad++;
          $display("FAIL combo_on got=%b%b want=10", pause_up, pause_down);
        end
      end else if (pause_up !== 1'b0) begin
        bad++;
        $display("FAIL combo_early got=%b want=0", pause_up);
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL combo_press_timeout got=none want=press"); end
    seen = 0;
    btn_raw[2] = 1'b0;
    sb.push_back('{5'b00000, 5'b00100, cyc + 11, cyc + 15});
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      total++;
      if (btn_release[2]) begin
        seen = 1;
        if (pause_up !== 1'b0 || btn_level !== 5'b00001) begin
          bad++;
          $display("FAIL combo_off got=%b/%b want=0/00001", pause_up, btn_level);
        end
      end else if (pause_up !== 1'b1) begin
        bad++;
        $display("FAIL combo_held got=%b want=1", pause_up);
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL combo_release_timeout got=none want=release"); end
    btn_raw[0] = 1'b0;
    sb.push_back('{5'b00000, 5'b00001, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL combo_final got=pending want=seen"); end
  endtask

  task automatic test_reset_mid();
    btn_raw[1] = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 8 && !tick_en; n++) step();
      step();
    end
    reset = 1'b0;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, tick_en} !== 16'd0) begin
      bad++;
      $display("FAIL midreset_async got=%h want=0", {btn_level, btn_press, btn_release, tick_en});
    end
    step();
    total++;
    if ({btn_level, btn_press, btn_release, pause_up, pause_down, tick_en} !== 18'd0) begin
      bad++;
      $display("FAIL midreset_held got=%h want=0", {btn_level, btn_press, btn_release, pause_up, pause_down, tick_en});
    end
    reset = 1'b1;
    sb.push_back('{5'b00010, 5'b00000, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0 || btn_level !== 5'b00010) begin
      bad++;
      $display("FAIL midreset_restart got=%b pending=%0d want=00010", btn_level, sb.size());
    end
  endtask

  task automatic test_repeat();
    int c, d, p, t0, l;
    btn_raw[1] = 1'b0;
    sb.push_back('{5'b00000, 5'b00010, cyc + 11, cyc + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL repeat_prep got=pending want=seen"); end
    c = cyc;
    d = c + 60;
    btn_raw[1] = 1'b1;
    sb.push_back('{5'b00010, 5'b00000, c + 11, c + 15});
    wait_sb(20);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL repeat_first_press got=pending want=seen"); end
    p = last_cyc;
    t0 = p + 4 * ((d + 3 - p + 3) / 4);
    l = t0 + 8;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    for (int t = p + 16; t < l; t += 8) sb.push_back('{5'b00010, 5'b00000, t, t});
`endif
    sb.push_back('{5'b00000, 5'b00010, l, l});
    while (cyc < d) step();
    btn_raw[1] = 1'b0;
    wait_sb(30);
    total++;
    if (sb.size() != 0 || btn_level !== 5'b00000) begin
      bad++;
      $display("FAIL repeat_release got=%b pending=%0d want=00000", btn_level, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_enter();
    test_bounce();
    test_combo();
    test_reset_mid();
    test_repeat();
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
